// File: rtl/connect4_batch_scheduler.sv
// Batch sequencer between the SPI slave and the Connect-4 board evaluator.
// Receives a batch, evaluates each board in turn, returns the best score.
module connect4_batch_scheduler #(
    parameter int SPI_RST_CYCLES = 4,
    parameter int EVAL_TIMEOUT   = 4096,
    parameter int MAX_BOARDS     = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rpi_data_stable,
    input  logic [7:0]               is_max_or_min,
    input  logic [7:0]               batch_size,
    input  logic [88*MAX_BOARDS-1:0] batch,
    input  logic                     done_sending,
    output logic                     spi_reset,
    output logic                     receive_or_send_data,
    output logic [31:0]              evaluation,
    output logic                     evaluation_stable,
    output logic                     board_valid,
    input  logic                     board_ready,
    output logic [83:0]              board,
    output logic [2:0]               board_index,
    input  logic                     eval_valid,
    input  logic [31:0]              eval_value,
    output logic [2:0]               best_index,
    output logic                     busy,
    output logic                     batch_error
);

    localparam int BW = 88 * MAX_BOARDS;
    localparam int CW = $clog2(SPI_RST_CYCLES + 1);
    localparam int TW = $clog2(EVAL_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPI_RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(EVAL_TIMEOUT - 1);
    localparam logic [7:0]    SIZE_MAX = 8'(MAX_BOARDS);

    typedef enum logic [2:0] {
        RST_RX, RECEIVE, DISPATCH, WAIT_EVAL, RST_TX, SEND
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [BW-1:0]  batch_q, batch_d;
    logic           mode_max_q, mode_max_d;
    logic [2:0]     n_q, n_d;
    logic [2:0]     k_q, k_d;
    logic [31:0]    best_q, best_d;
    logic [2:0]     best_idx_q, best_idx_d;
    logic           best_vld_q, best_vld_d;
    logic           spi_reset_q, spi_reset_d;
    logic           rxtx_q, rxtx_d;
    logic [31:0]    evaluation_q, evaluation_d;
    logic           eval_stable_q, eval_stable_d;
    logic           board_valid_q, board_valid_d;
    logic [83:0]    board_q, board_d;
    logic [2:0]     board_index_q, board_index_d;
    logic [2:0]     best_index_q, best_index_d;
    logic           busy_q, busy_d;
    logic           batch_error_q, batch_error_d;

    logic           go_tx;
    logic           advance;
    logic           better;
    logic [2:0]     k_nxt;
    logic           unused_mode_bits;

    assign unused_mode_bits = ^is_max_or_min[7:1];

    // Cells of slot k; the low 4 bits of each 88-bit slot are padding.
    function automatic logic [83:0] cells(input logic [BW-1:0] b,
                                          input logic [2:0] k);
        return b[88*int'(k)+4 +: 84];
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        batch_d       = batch_q;
        mode_max_d    = mode_max_q;
        n_d           = n_q;
        k_d           = k_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        best_vld_d    = best_vld_q;
        spi_reset_d   = spi_reset_q;
        rxtx_d        = rxtx_q;
        evaluation_d  = evaluation_q;
        eval_stable_d = eval_stable_q;
        board_valid_d = board_valid_q;
        board_d       = board_q;
        board_index_d = board_index_q;
        best_index_d  = best_index_q;
        batch_error_d = batch_error_q;
        go_tx         = 1'b0;
        advance       = 1'b0;
        better        = 1'b0;
        k_nxt         = k_q + 3'd1;

        unique case (state_q)
            RST_RX: begin
                rxtx_d        = 1'b1;
                batch_error_d = 1'b0;
                best_d        = '0;
                best_idx_d    = '0;
                best_vld_d    = 1'b0;
                k_d           = '0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    spi_reset_d = 1'b1;
                    state_d     = RECEIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECEIVE: begin
                if (rpi_data_stable) begin
                    batch_d    = batch;
                    mode_max_d = is_max_or_min[0];
                    if (batch_size == 8'd0) begin
                        n_d           = '0;
                        batch_error_d = 1'b1;
                        go_tx         = 1'b1;
                    end else begin
                        if (batch_size > SIZE_MAX) begin
                            n_d           = SIZE_MAX[2:0];
                            batch_error_d = 1'b1;
                        end else begin
                            n_d = batch_size[2:0];
                        end
                        state_d       = DISPATCH;
                        board_valid_d = 1'b1;
                        board_d       = cells(batch, 3'd0);
                        board_index_d = '0;
                    end
                end
            end
            DISPATCH: begin
                if (board_ready) begin
                    board_valid_d = 1'b0;
                    timer_d       = '0;
                    state_d       = WAIT_EVAL;
                end
            end
            WAIT_EVAL: begin
                timer_d = timer_q + 1'b1;
                if (eval_valid) begin
                    advance = 1'b1;
                    better  = mode_max_q
                        ? ($signed(eval_value) > $signed(best_q))
                        : ($signed(eval_value) < $signed(best_q));
                    if (!best_vld_q || better) begin
                        best_d     = eval_value;
                        best_idx_d = k_q;
                        best_vld_d = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    advance       = 1'b1;
                    batch_error_d = 1'b1;
                end
                if (advance) begin
                    k_d = k_nxt;
                    if (k_nxt == n_q) begin
                        go_tx = 1'b1;
                    end else begin
                        state_d       = DISPATCH;
                        board_valid_d = 1'b1;
                        board_d       = cells(batch_q, k_nxt);
                        board_index_d = k_nxt;
                    end
                end
            end
            RST_TX: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    spi_reset_d = 1'b1;
                    state_d     = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                // One settle cycle after SPI release before flagging data.
                if (!eval_stable_q) begin
                    eval_stable_d = 1'b1;
                end else if (done_sending) begin
                    eval_stable_d = 1'b0;
                    spi_reset_d   = 1'b0;
                    rxtx_d        = 1'b1;
                    cnt_d         = '0;
                    state_d       = RST_RX;
                end
            end
            default: state_d = RST_RX;
        endcase

        if (go_tx) begin
            state_d      = RST_TX;
            spi_reset_d  = 1'b0;
            rxtx_d       = 1'b0;
            cnt_d        = '0;
            evaluation_d = best_d;
            best_index_d = best_idx_d;
        end

        busy_d = (state_d != RECEIVE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RST_RX;
            cnt_q         <= '0;
            timer_q       <= '0;
            batch_q       <= '0;
            mode_max_q    <= 1'b0;
            n_q           <= '0;
            k_q           <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            best_vld_q    <= 1'b0;
            spi_reset_q   <= 1'b0;
            rxtx_q        <= 1'b1;
            evaluation_q  <= '0;
            eval_stable_q <= 1'b0;
            board_valid_q <= 1'b0;
            board_q       <= '0;
            board_index_q <= '0;
            best_index_q  <= '0;
            busy_q        <= 1'b1;
            batch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            batch_q       <= batch_d;
            mode_max_q    <= mode_max_d;
            n_q           <= n_d;
            k_q           <= k_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            best_vld_q    <= best_vld_d;
            spi_reset_q   <= spi_reset_d;
            rxtx_q        <= rxtx_d;
            evaluation_q  <= evaluation_d;
            eval_stable_q <= eval_stable_d;
            board_valid_q <= board_valid_d;
            board_q       <= board_d;
            board_index_q <= board_index_d;
            best_index_q  <= best_index_d;
            busy_q        <= busy_d;
            batch_error_q <= batch_error_d;
        end
    end

    assign spi_reset            = spi_reset_q;
    assign receive_or_send_data = rxtx_q;
    assign evaluation           = evaluation_q;
    assign evaluation_stable    = eval_stable_q;
    assign board_valid          = board_valid_q;
    assign board                = board_q;
    assign board_index          = board_index_q;
    assign best_index           = best_index_q;
    assign busy                 = busy_q;
    assign batch_error          = batch_error_q;

endmodule
